// File: rtl/pwm_audio_out.sv
// pwm_audio_out: converts the unsigned 8-bit audio stream from the distortion
// stage into a single-bit PWM waveform for the board's low-pass filter.
// One sample is buffered and moved into the duty register only at the end of
// a PWM period, so every output period has a single, stable duty value.
// Underrun (period ended with nothing buffered) and overrun (buffered sample
// overwritten before use) are reported as sticky flags.
module pwm_audio_out #(
    parameter int unsigned CLK_DIV   = 1,
    parameter logic [7:0]  IDLE_DUTY = 8'h80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic       enable,
    input  logic       clear_flags,
    output logic       pwm_out,
    output logic       period_start,
    output logic       underrun,
    output logic       overrun
);

    // Prescaler needs at least one bit even when it never leaves zero.
    localparam int unsigned      PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    // State registers
    logic [PRE_W-1:0] prescaler_r;
    logic [7:0]       pwm_cnt_r;
    logic [7:0]       duty_r;
    logic [7:0]       pending_r;
    logic             pending_full_r;
    logic             pwm_out_r;
    logic             period_start_r;
    logic             underrun_r;
    logic             overrun_r;

    // Next-state and event signals
    logic             tick_s;
    logic             boundary_s;
    logic [PRE_W-1:0] prescaler_nxt_s;
    logic [7:0]       pwm_cnt_nxt_s;
    logic [7:0]       duty_nxt_s;
    logic [7:0]       pending_nxt_s;
    logic             pending_full_nxt_s;
    logic             pwm_out_nxt_s;
    logic             set_underrun_s;
    logic             set_overrun_s;
    logic             underrun_nxt_s;
    logic             overrun_nxt_s;

    // Timebase: prescaler tick and end-of-period detection, next counter values.
    always_comb begin
        tick_s          = (prescaler_r == PRE_LAST);
        boundary_s      = tick_s && (pwm_cnt_r == 8'hFF);
        prescaler_nxt_s = prescaler_r;
        pwm_cnt_nxt_s   = pwm_cnt_r;
        if (tick_s) begin
            prescaler_nxt_s = '0;
            pwm_cnt_nxt_s   = pwm_cnt_r + 8'd1;
        end else begin
            prescaler_nxt_s = prescaler_r + PRE_W'(1'b1);
            pwm_cnt_nxt_s   = pwm_cnt_r;
        end
    end

    // Sample buffering: capture into pending, hand pending over to duty at the boundary.
    always_comb begin
        pending_nxt_s      = pending_r;
        pending_full_nxt_s = pending_full_r;
        duty_nxt_s         = duty_r;
        // A new sample always lands in pending; latest sample wins.
        if (sample_valid) begin
            pending_nxt_s      = sample_in;
            pending_full_nxt_s = 1'b1;
        end else if (boundary_s) begin
            pending_full_nxt_s = 1'b0;
        end else begin
            pending_full_nxt_s = pending_full_r;
        end
        // With nothing buffered the previous duty is held for another period.
        if (boundary_s && pending_full_r) begin
            duty_nxt_s = pending_r;
        end else begin
            duty_nxt_s = duty_r;
        end
    end

    // Sticky status flags: a set event in the same cycle beats clear_flags.
    always_comb begin
        set_underrun_s = boundary_s && !pending_full_r;
        // At a boundary the old pending moves to duty, so nothing is lost.
        set_overrun_s  = sample_valid && pending_full_r && !boundary_s;
        underrun_nxt_s = underrun_r;
        overrun_nxt_s  = overrun_r;
        if (set_underrun_s) begin
            underrun_nxt_s = 1'b1;
        end else if (clear_flags) begin
            underrun_nxt_s = 1'b0;
        end else begin
            underrun_nxt_s = underrun_r;
        end
        if (set_overrun_s) begin
            overrun_nxt_s = 1'b1;
        end else if (clear_flags) begin
            overrun_nxt_s = 1'b0;
        end else begin
            overrun_nxt_s = overrun_r;
        end
    end

    // PWM comparator; enable only gates the output, never the timebase.
    always_comb begin
        pwm_out_nxt_s = 1'b0;
        if (enable) begin
            pwm_out_nxt_s = (pwm_cnt_r < duty_r);
        end else begin
            pwm_out_nxt_s = 1'b0;
        end
    end

    // State update with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler_r    <= '0;
            pwm_cnt_r      <= 8'h00;
            duty_r         <= IDLE_DUTY;
            pending_r      <= 8'h00;
            pending_full_r <= 1'b0;
            pwm_out_r      <= 1'b0;
            period_start_r <= 1'b0;
            underrun_r     <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            prescaler_r    <= prescaler_nxt_s;
            pwm_cnt_r      <= pwm_cnt_nxt_s;
            duty_r         <= duty_nxt_s;
            pending_r      <= pending_nxt_s;
            pending_full_r <= pending_full_nxt_s;
            pwm_out_r      <= pwm_out_nxt_s;
            period_start_r <= boundary_s;
            underrun_r     <= underrun_nxt_s;
            overrun_r      <= overrun_nxt_s;
        end
    end

    assign sample_ready = !pending_full_r;
    assign pwm_out      = pwm_out_r;
    assign period_start = period_start_r;
    assign underrun     = underrun_r;
    assign overrun      = overrun_r;

endmodule
